// File: rtl/pipe_pkg.sv
// Shared definitions for the front-end elastic stage buffer and its helpers:
// wrap-aware instruction age compare and the occupancy-width helper.
package pipe_pkg;

    // Widest id the age compare supports; callers zero-extend their ids.
    localparam int unsigned ID_MAX_W  = 32;
    localparam int unsigned DEF_DEPTH = 2;

    // Occupancy counter width for a buffer of the given depth (0..depth inclusive).
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    typedef logic [cnt_width(DEF_DEPTH)-1:0] pipe_cnt_t;

    // a is younger than b iff (a - b) mod 2^w lies in [1, 2^(w-1)-1].
    // Arguments are carried at ID_MAX_W and masked down to the caller's width w,
    // so one function serves every id width; w is a constant at each call site.
    function automatic logic id_younger(input logic [ID_MAX_W-1:0] a,
                                        input logic [ID_MAX_W-1:0] b,
                                        input int unsigned         w);
        logic [ID_MAX_W-1:0] mask;
        logic [ID_MAX_W-1:0] diff;
        logic [ID_MAX_W-1:0] half;
        mask = (w >= ID_MAX_W) ? '1 : ((ID_MAX_W'(1) << w) - ID_MAX_W'(1));
        diff = (a - b) & mask;
        half = ID_MAX_W'(1) << (w - 1);
        return (diff != '0) && (diff < half);
    endfunction

endpackage

// File: rtl/pipe_kill_scan.sv
// Selective-kill scan: given ids ordered from the head and the occupancy,
// returns how many leading entries survive a kill of ids younger than kill_id_i.
module pipe_kill_scan
    import pipe_pkg::*;
#(
    parameter int unsigned ID_W  = 8,
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic [DEPTH-1:0][ID_W-1:0] ids_i,
    input  logic [CNT_W-1:0]           occ_i,
    input  logic [ID_W-1:0]            kill_id_i,
    output logic [CNT_W-1:0]           keep_o,
    output logic                       hit_o
);

    // First valid entry (in program order) that is younger than the kill id.
    always_comb begin
        keep_o = occ_i;
        hit_o  = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (!hit_o && (CNT_W'(i) < occ_i) &&
                id_younger(ID_MAX_W'(ids_i[i]), ID_MAX_W'(kill_id_i), ID_W)) begin
                keep_o = CNT_W'(i);
                hit_o  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pipe_stage_buf.sv
// Elastic in-order stage buffer with full flush and selective kill.
// Optional build macro PIPE_STAGE_BUF_BYPASS_EN: forward the input straight to
// the output when the buffer is empty (zero-latency path).
module pipe_stage_buf
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned ID_W   = 8,
    parameter int unsigned DEPTH  = 2
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_W-1:0]          in_data,
    input  logic [ID_W-1:0]            in_id,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_data,
    output logic [ID_W-1:0]            out_id,
    input  logic                       flush_i,
    input  logic                       kill_valid_i,
    input  logic [ID_W-1:0]            kill_id_i,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = cnt_width(DEPTH);

    logic [DATA_W-1:0] data_q [DEPTH];
    logic [ID_W-1:0]   id_q   [DEPTH];
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic              full, empty;
    logic              in_killed;
    logic              byp, byp_take;
    logic              push_st, pop_st;
    logic [PTR_W-1:0]  head_pop;
    logic [CNT_W-1:0]  occ_pop;
    logic [DEPTH-1:0][ID_W-1:0] ids_ord;
    logic [CNT_W-1:0]  scan_keep;
    logic              scan_hit;
    logic              wr_en;
    logic [PTR_W-1:0]  wr_ptr;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);

    // in_ready is a function of registered state only.
    assign in_ready = rstn && !full;

    assign in_killed = kill_valid_i &&
                       id_younger(ID_MAX_W'(in_id), ID_MAX_W'(kill_id_i), ID_W);

`ifdef PIPE_STAGE_BUF_BYPASS_EN
    assign byp      = rstn && empty && in_valid && !flush_i && !in_killed;
    assign byp_take = byp && out_ready;
`else
    assign byp      = 1'b0;
    assign byp_take = 1'b0;
`endif

    assign pop_st  = !empty && out_ready;
    assign push_st = in_valid && in_ready && !byp_take && !in_killed;

    assign head_pop = pop_st ? head_q + 1'b1 : head_q;
    assign occ_pop  = pop_st ? count_q - 1'b1 : count_q;

    // Present surviving entries to the kill scan in program order from the post-pop head.
    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            ids_ord[i] = id_q[head_pop + PTR_W'(i)];
        end
    end

    pipe_kill_scan #(
        .ID_W  (ID_W),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_kill_scan (
        .ids_i     (ids_ord),
        .occ_i     (occ_pop),
        .kill_id_i (kill_id_i),
        .keep_o    (scan_keep),
        .hit_o     (scan_hit)
    );

    // Next pointers/count: flush wins; otherwise pop, then kill truncation, then push at the new tail.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        wr_en   = 1'b0;
        wr_ptr  = tail_q;
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            head_d  = head_pop;
            count_d = occ_pop;
            if (kill_valid_i && scan_hit) begin
                tail_d  = head_pop + PTR_W'(scan_keep);
                count_d = scan_keep;
            end
            if (push_st) begin
                wr_en   = 1'b1;
                wr_ptr  = tail_d;
                tail_d  = tail_d + 1'b1;
                count_d = count_d + 1'b1;
            end
        end
    end

    // Pointer and occupancy registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Payload storage; no reset needed since entries are only read when counted valid.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            data_q[wr_ptr] <= in_data;
            id_q[wr_ptr]   <= in_id;
        end
    end

    assign out_valid = !empty || byp;
    assign out_data  = byp ? in_data : data_q[head_q];
    assign out_id    = byp ? in_id   : id_q[head_q];
    assign count_o   = count_q;
    assign full_o    = full;
    assign empty_o   = empty;

`ifndef SYNTHESIS
    // Upstream must hold a refused payload stable until it is accepted.
    a_in_hold : assert property (@(posedge clk) disable iff (!rstn)
        (in_valid && !in_ready) |=> (in_valid && $stable(in_data)));
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed self-checking bench for pipe_stage_buf (DEPTH=4, ID_W=8, DATA_W=16).
module tb_pipe_stage_buf;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned ID_W   = 8;
    localparam int unsigned DEPTH  = 4;

    logic              clk = 1'b0;
    logic              rstn;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [ID_W-1:0]   in_id;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [ID_W-1:0]   out_id;
    logic              flush_i;
    logic              kill_valid_i;
    logic [ID_W-1:0]   kill_id_i;
    logic [2:0]        count_o;
    logic              full_o;
    logic              empty_o;

    int n_checks = 0;
    int n_errors = 0;

    pipe_stage_buf #(
        .DATA_W (DATA_W),
        .ID_W   (ID_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_id        (in_id),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_id       (out_id),
        .flush_i      (flush_i),
        .kill_valid_i (kill_valid_i),
        .kill_id_i    (kill_id_i),
        .count_o      (count_o),
        .full_o       (full_o),
        .empty_o      (empty_o)
    );

    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] dat(input logic [ID_W-1:0] id);
        return {8'hA5, id};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drive one cycle of stimulus, clock it, and settle 1 time unit after the edge.
    task automatic cyc(input logic iv, input logic [ID_W-1:0] id, input logic ordy,
                       input logic fl, input logic kv, input logic [ID_W-1:0] kid);
        in_valid     = iv;
        in_id        = id;
        in_data      = dat(id);
        out_ready    = ordy;
        flush_i      = fl;
        kill_valid_i = kv;
        kill_id_i    = kid;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [ID_W-1:0] id);
        cyc(1'b1, id, 1'b0, 1'b0, 1'b0, 8'd0);
    endtask

    // Check head id/data, then consume it.
    task automatic pop_expect(input string tag, input logic [ID_W-1:0] id);
        check_eq({tag, "_vld"}, 32'(out_valid), 32'd1);
        check_eq({tag, "_id"}, 32'(out_id), 32'(id));
        check_eq({tag, "_data"}, 32'(out_data), 32'(dat(id)));
        cyc(1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 8'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rstn = 1'b0;
        in_valid = 1'b0; in_id = '0; in_data = '0; out_ready = 1'b0;
        flush_i = 1'b0; kill_valid_i = 1'b0; kill_id_i = '0;
        repeat (3) begin @(posedge clk); #1; end

        // Reset state
        check_eq("rst_in_ready", 32'(in_ready), 32'd0);
        check_eq("rst_count", 32'(count_o), 32'd0);
        check_eq("rst_empty", 32'(empty_o), 32'd1);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        rstn = 1'b1;
        cyc(1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 8'd0);
        check_eq("idle_in_ready", 32'(in_ready), 32'd1);
        check_eq("idle_out_valid", 32'(out_valid), 32'd0);
        check_eq("idle_empty", 32'(empty_o), 32'd1);
        check_eq("idle_full", 32'(full_o), 32'd0);

        // Fill to DEPTH
        for (int i = 0; i < 4; i++) begin
            push(8'(10 + i));
            check_eq("fill_count", 32'(count_o), 32'(i + 1));
        end
        check_eq("fill_full", 32'(full_o), 32'd1);
        check_eq("fill_in_ready", 32'(in_ready), 32'd0);
        check_eq("fill_head", 32'(out_id), 32'd10);

        // Full buffer refuses a push even with a same-cycle pop
        cyc(1'b1, 8'd14, 1'b1, 1'b0, 1'b0, 8'd0);
        check_eq("fullpop_count", 32'(count_o), 32'd3);
        check_eq("fullpop_head", 32'(out_id), 32'd11);
        cyc(1'b1, 8'd14, 1'b0, 1'b0, 1'b0, 8'd0);
        check_eq("fullpop_refill", 32'(count_o), 32'd4);
        for (int i = 0; i < 4; i++) pop_expect("drain1", 8'(11 + i));
        check_eq("drain1_empty", 32'(empty_o), 32'd1);

        // Steady stream at count 2
        push(8'd30);
        push(8'd31);
        for (int i = 0; i < 6; i++) begin
            check_eq("stream_id", 32'(out_id), 32'(30 + i));
            cyc(1'b1, 8'(32 + i), 1'b1, 1'b0, 1'b0, 8'd0);
            check_eq("stream_count", 32'(count_o), 32'd2);
        end
        pop_expect("stream_tail", 8'd36);
        pop_expect("stream_tail", 8'd37);
        check_eq("stream_empty", 32'(empty_o), 32'd1);

        // Selective kill without pop
        for (int i = 0; i < 4; i++) push(8'(20 + i));
        cyc(1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 8'd21);
        check_eq("kill_count", 32'(count_o), 32'd2);
        pop_expect("kill_out", 8'd20);
        pop_expect("kill_out", 8'd21);
        check_eq("kill_empty", 32'(empty_o), 32'd1);

        // Selective kill with pop of the head in the same cycle
        for (int i = 0; i < 4; i++) push(8'(20 + i));
        cyc(1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 8'd21);
        check_eq("killpop_count", 32'(count_o), 32'd1);
        pop_expect("killpop_out", 8'd21);
        check_eq("killpop_empty", 32'(empty_o), 32'd1);

        // Wrap-around ids: 0 is younger than 255; push of 2 dropped
        push(8'd254);
        push(8'd255);
        push(8'd0);
        cyc(1'b1, 8'd2, 1'b0, 1'b0, 1'b1, 8'd255);
        check_eq("wrap_count", 32'(count_o), 32'd2);
        // Older push survives a kill and lands at the truncated tail
        cyc(1'b1, 8'd250, 1'b0, 1'b0, 1'b1, 8'd255);
        check_eq("wrap_push_old", 32'(count_o), 32'd3);
        // Kill with no younger entry changes nothing
        cyc(1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 8'd100);
        check_eq("kill_nomatch", 32'(count_o), 32'd3);
        pop_expect("wrap_out", 8'd254);
        pop_expect("wrap_out", 8'd255);
        pop_expect("wrap_out", 8'd250);
        check_eq("wrap_empty", 32'(empty_o), 32'd1);

        // Flush with push and pop active
        push(8'd40);
        push(8'd41);
        push(8'd42);
        cyc(1'b1, 8'd43, 1'b1, 1'b1, 1'b1, 8'd0);
        check_eq("flush_count", 32'(count_o), 32'd0);
        check_eq("flush_out_valid", 32'(out_valid), 32'd0);
        push(8'd44);
        check_eq("postflush_count", 32'(count_o), 32'd1);
        pop_expect("postflush", 8'd44);

`ifdef PIPE_STAGE_BUF_BYPASS_EN
        // Zero-latency forward when empty and downstream ready
        in_valid = 1'b1; in_id = 8'd50; in_data = dat(8'd50); out_ready = 1'b1;
        #1;
        check_eq("byp_valid", 32'(out_valid), 32'd1);
        check_eq("byp_id", 32'(out_id), 32'd50);
        cyc(1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 8'd0);
        check_eq("byp_count", 32'(count_o), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
